sensor_scan_ctrl: RTL and testbench

Sequencer that polls the four baggage-height sensors through one shared 8-bit sensor port. It selects each sensor in turn, waits a settle time, captures the reading, and computes the drop height. The result is presented downstream on a valid/ready handshake. It sits between the external sensor mux and the baggage-drop control logic, and replaces four parallel sensor buses with one scanned bus.

---
 rtl/sensor_scan_ctrl_pkg.sv | 15 +
 rtl/sensor_scan_ctrl_if.sv | 25 ++
 rtl/sensor_scan_ctrl_height_avg.sv | 45 ++++
 rtl/sensor_scan_ctrl.sv | 110 +++++++++++
 tb/tb_sensor_scan_ctrl.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared baggage-line package: scan FSM states and sensor/height sizing constants.
package baggage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } scan_state_e;

    localparam int unsigned SENSOR_CNT = 4;
    localparam int unsigned HEIGHT_W   = 8;
    localparam int unsigned SUM_W      = HEIGHT_W + 2;

endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Scanned sensor port plus the start/busy control and the height valid/ready result channel.
interface sensor_scan_if
    import baggage_pkg::*;
#(
    parameter int unsigned DATA_W = 8
);
    logic                  start;
    logic                  busy;
    logic [1:0]            sensor_sel;
    logic [DATA_W-1:0]     sensor_data;
    logic [DATA_W-1:0]     height;
    logic [SENSOR_CNT-1:0] sensor_zero;
    logic                  height_valid;
    logic                  height_ready;

    modport master (
        output start, sensor_data, height_ready,
        input  busy, sensor_sel, height, sensor_zero, height_valid
    );

    modport slave (
        input  start, sensor_data, height_ready,
        output busy, sensor_sel, height, sensor_zero, height_valid
    );
endinterface

// File: rtl/sensor_scan_ctrl_height_avg.sv
// Combinational drop-height estimate from four captured sensor readings, with zero flags.
module sensor_height_avg
    import baggage_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [SENSOR_CNT-1:0][DATA_W-1:0] samples_i,
    output logic [DATA_W-1:0]                 height_o,
    output logic [SENSOR_CNT-1:0]             zero_o
);
    localparam int unsigned SW = DATA_W + 2;

    function automatic logic [DATA_W-1:0] round_mean2(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(1);
        return DATA_W'(s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] round_mean4(input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b,
                                                      input logic [DATA_W-1:0] c,
                                                      input logic [DATA_W-1:0] d);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(c) + SW'(d) + SW'(2);
        return DATA_W'(s >> 2);
    endfunction

    always_comb begin
        for (int i = 0; i < SENSOR_CNT; i++) begin
            zero_o[i] = (samples_i[i] == '0);
        end
    end

    // A dead sensor drops its opposite pair; the remaining pair is averaged.
    always_comb begin
        if (zero_o[0] || zero_o[2]) begin
            height_o = round_mean2(samples_i[1], samples_i[3]);
        end else if (zero_o[1] || zero_o[3]) begin
            height_o = round_mean2(samples_i[0], samples_i[2]);
        end else begin
            height_o = round_mean4(samples_i[0], samples_i[1], samples_i[2], samples_i[3]);
        end
    end
endmodule

// File: rtl/sensor_scan_ctrl.sv
// Scans four height sensors over one shared port and publishes the drop height on valid/ready.
// Define SENSOR_SCAN_AUTO_EN for continuous rescanning after each accepted result.
module sensor_scan_ctrl
    import baggage_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DATA_W        = 8
) (
    input logic         clk,
    input logic         rst_n,
    sensor_scan_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    scan_state_e                       state_q, state_d;
    logic [1:0]                        sel_q, sel_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [SENSOR_CNT-1:0][DATA_W-1:0] slot_q, slot_d;
    logic [DATA_W-1:0]                 height_q, height_d;
    logic [SENSOR_CNT-1:0]             zero_q, zero_d;
    logic                              vld_q, vld_d;
    logic [DATA_W-1:0]                 avg_height;
    logic [SENSOR_CNT-1:0]             avg_zero;

    sensor_height_avg #(.DATA_W(DATA_W)) u_avg (
        .samples_i (slot_q),
        .height_o  (avg_height),
        .zero_o    (avg_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        height_d = height_q;
        zero_d   = zero_q;
        vld_d    = vld_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                    slot_d[sel_q] = bus.sensor_data;
                    cnt_d         = '0;
                    if (sel_q == 2'(SENSOR_CNT - 1)) begin
                        state_d = COMPUTE;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMPUTE: begin
                height_d = avg_height;
                zero_d   = avg_zero;
                vld_d    = 1'b1;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                if (bus.height_ready) begin
                    vld_d = 1'b0;
`ifdef SENSOR_SCAN_AUTO_EN
                    state_d = SCAN;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            height_q <= '0;
            zero_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            height_q <= height_d;
            zero_q   <= zero_d;
            vld_q    <= vld_d;
        end
    end

    // Capture slots are always overwritten before COMPUTE reads them, so they need no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.sensor_sel   = sel_q;
    assign bus.height       = height_q;
    assign bus.sensor_zero  = zero_q;
    assign bus.height_valid = vld_q;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl; sensor readings are served from a table indexed by sensor_sel.
module tb_sensor_scan_ctrl;
    logic clk;
    logic rst_n;
    logic [7:0] rd [4];
    int n_chk;
    int n_err;

    sensor_scan_if #(.DATA_W(8)) bus ();

    sensor_scan_ctrl #(.SETTLE_CYCLES(4), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb bus.sensor_data = rd[bus.sensor_sel];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.height_valid), 0);
        chk("rst_height", 32'(bus.height), 0);
        chk("rst_zero",  32'(bus.sensor_zero), 0);
        chk("rst_sel",   32'(bus.sensor_sel), 0);
    endtask

    task automatic do_scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] eh, input logic [3:0] ez);
        int k;
        rd[0] = a; rd[1] = b; rd[2] = c; rd[3] = d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_rise", 32'(bus.busy), 1);
        k = 0;
        while (!bus.height_valid && k < 40) begin
            if (k < 20 && (k % 5) == 0) chk("sel_step", 32'(bus.sensor_sel), 32'(k / 5));
            tick();
            k++;
        end
        chk("latency", 32'(k), 21);
        chk("height", 32'(bus.height), 32'(eh));
        chk("zero", 32'(bus.sensor_zero), 32'(ez));
    endtask

    initial begin
        int bad;
        int k;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.height_ready = 1'b1;
        for (int i = 0; i < 4; i++) rd[i] = 8'd0;
        tick();
        tick();
        check_reset_state();
        rst_n = 1'b1;
        tick();

`ifdef SENSOR_SCAN_AUTO_EN
        do_scan(8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 4'b0000);
        for (int r = 0; r < 3; r++) begin
            k = 0;
            bad = 0;
            do begin
                tick();
                k++;
                if (!bus.busy) bad++;
            end while (!bus.height_valid && k < 40);
            chk("auto_period", 32'(k), 22);
            chk("auto_busy", 32'(bad), 0);
            chk("auto_height", 32'(bus.height), 25);
        end
`else
        do_scan(8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 4'b0000);
        tick();
        chk("valid_fall", 32'(bus.height_valid), 0);
        chk("busy_fall", 32'(bus.busy), 0);

        do_scan(8'd0, 8'd7, 8'd50, 8'd8, 8'd8, 4'b0001);
        tick();
        do_scan(8'd9, 8'd0, 8'd10, 8'd33, 8'd10, 4'b0010);
        tick();
        do_scan(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 4'b0000);
        tick();
        do_scan(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b1111);
        tick();
        do_scan(8'd6, 8'd0, 8'd0, 8'd9, 8'd5, 4'b0110);
        tick();

        // Backpressure: result must hold while a stray start is ignored.
        bus.height_ready = 1'b0;
        do_scan(8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("hold_valid", 32'(bus.height_valid), 1);
            chk("hold_height", 32'(bus.height), 3);
        end
        bus.height_ready = 1'b1;
        tick();
        chk("bp_valid_fall", 32'(bus.height_valid), 0);
        chk("bp_busy_fall", 32'(bus.busy), 0);
        bad = 0;
        repeat (25) begin
            tick();
            if (bus.height_valid || bus.busy) bad++;
        end
        chk("no_rescan", 32'(bad), 0);

        // Reset in the middle of a scan.
        rd[0] = 8'd10; rd[1] = 8'd20; rd[2] = 8'd30; rd[3] = 8'd40;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state();
        do_scan(8'd100, 8'd50, 8'd60, 8'd70, 8'd70, 4'b0000);
        tick();
        chk("final_valid_fall", 32'(bus.height_valid), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
